can_tx_sched: RTL



---
 rtl/can_tx_sched.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/can_tx_sched.sv
// can_tx_sched: mailbox transmit scheduler multiplexing the CAN core register port with host accesses.
// Define CAN_TX_SCHED_TIMEOUT_EN to force an abort when a frame outlives TX_TIMEOUT cycles after CMR.
module can_tx_sched #(
    parameter int NUM_SLOTS  = 4,
    parameter int POLL_GAP   = 16,
    parameter int TX_TIMEOUT = 65535,
    localparam int SW = $clog2(NUM_SLOTS)
) (
    input  logic                 PCLK,
    input  logic                 PRESETn_synch,
    input  logic                 host_req,
    input  logic                 host_we,
    input  logic [7:0]           host_addr,
    input  logic [7:0]           host_wdata,
    output logic [7:0]           host_rdata,
    output logic                 host_ack,
    input  logic                 mb_wr,
    input  logic [SW-1:0]        mb_slot,
    input  logic [3:0]           mb_idx,
    input  logic [7:0]           mb_wdata,
    input  logic                 mb_submit,
    input  logic                 mb_abort,
    output logic [NUM_SLOTS-1:0] slot_pending,
    output logic                 done_pulse,
    output logic [SW-1:0]        done_slot,
    output logic                 done_err,
    output logic                 can_cs,
    output logic                 can_we,
    output logic [7:0]           can_addr,
    output logic [7:0]           can_wdata,
    input  logic [7:0]           can_rdata
);

    localparam int GW = $clog2(POLL_GAP + 1);

    typedef enum logic [3:0] {IDLE, HOST, RD_TBS, CK_TBS, LOAD, CMD, GAP, RD_SR, CK_SR, ABRT, DONE} state_t;

    state_t                r_state, r_ret;
    logic [7:0]            r_mb [NUM_SLOTS][13];
    logic [NUM_SLOTS-1:0]  r_pending;
    logic [SW-1:0]         r_active;
    logic                  r_busy, r_abort, r_abort_sent, r_err, r_gap_tbs;
    logic [3:0]            r_idx;
    logic [GW-1:0]         r_gap;
    logic [SW-1:0]         w_low;
    logic                  w_any, w_grant, w_slot_ok, w_tmo_hit;

    assign slot_pending = r_pending;
    assign w_any        = |r_pending;
    assign w_slot_ok    = int'(mb_slot) < NUM_SLOTS;
    assign w_grant      = host_req && !host_ack && (r_state == IDLE || r_state == GAP);

    always_comb begin
        w_low = '0;
        for (int i = NUM_SLOTS - 1; i >= 0; i--)
            if (r_pending[i]) w_low = SW'(i);
    end

`ifdef CAN_TX_SCHED_TIMEOUT_EN
    logic [15:0] r_tmo;
    logic        r_tmo_run;

    assign w_tmo_hit = r_tmo_run && r_tmo == 16'(TX_TIMEOUT - 1);

    always_ff @(posedge PCLK or negedge PRESETn_synch) begin
        if (!PRESETn_synch) begin
            r_tmo     <= '0;
            r_tmo_run <= 1'b0;
        end else if (r_state == CMD) begin
            r_tmo     <= '0;
            r_tmo_run <= 1'b1;
        end else if (r_state == DONE || w_tmo_hit) begin
            r_tmo_run <= 1'b0;
        end else if (r_tmo_run) begin
            r_tmo <= r_tmo + 16'd1;
        end
    end
`else
    assign w_tmo_hit = 1'b0;
`endif

    always_ff @(posedge PCLK or negedge PRESETn_synch) begin
        if (!PRESETn_synch) begin
            r_state      <= IDLE;
            r_ret        <= IDLE;
            r_pending    <= '0;
            r_active     <= '0;
            r_busy       <= 1'b0;
            r_abort      <= 1'b0;
            r_abort_sent <= 1'b0;
            r_err        <= 1'b0;
            r_gap_tbs    <= 1'b0;
            r_idx        <= '0;
            r_gap        <= '0;
            host_rdata   <= '0;
            host_ack     <= 1'b0;
            done_pulse   <= 1'b0;
            done_slot    <= '0;
            done_err     <= 1'b0;
            can_cs       <= 1'b0;
            can_we       <= 1'b0;
            can_addr     <= '0;
            can_wdata    <= '0;
            for (int s = 0; s < NUM_SLOTS; s++)
                for (int b = 0; b < 13; b++)
                    r_mb[s][b] <= '0;
        end else begin
            can_cs     <= 1'b0;
            host_ack   <= 1'b0;
            done_pulse <= 1'b0;
            if (mb_wr && w_slot_ok && !r_pending[mb_slot] && mb_idx <= 4'd12)
                r_mb[mb_slot][mb_idx] <= mb_wdata;
            if (mb_submit && w_slot_ok && !r_pending[mb_slot])
                r_pending[mb_slot] <= 1'b1;
            // The in-flight frame cannot be withdrawn locally; it must be aborted in the core.
            if (mb_abort && w_slot_ok && r_pending[mb_slot]) begin
                if (r_busy && mb_slot == r_active) r_abort <= 1'b1;
                else r_pending[mb_slot] <= 1'b0;
            end
            if (w_tmo_hit) r_abort <= 1'b1;
            if (w_grant) begin
                can_cs    <= 1'b1;
                can_we    <= host_we;
                can_addr  <= host_addr;
                can_wdata <= host_wdata;
                r_ret     <= r_state;
                r_state   <= HOST;
            end else begin
                case (r_state)
                    IDLE: if (w_any && !(mb_abort && mb_slot == w_low)) begin
                        r_active     <= w_low;
                        r_busy       <= 1'b1;
                        r_abort      <= 1'b0;
                        r_abort_sent <= 1'b0;
                        r_state      <= RD_TBS;
                    end
                    HOST: begin
                        host_ack <= 1'b1;
                        if (!can_we) host_rdata <= can_rdata;
                        r_state <= r_ret;
                    end
                    RD_TBS, RD_SR: begin
                        can_cs   <= 1'b1;
                        can_we   <= 1'b0;
                        can_addr <= 8'd2;
                        r_state  <= r_state == RD_TBS ? CK_TBS : CK_SR;
                    end
                    CK_TBS: begin
                        r_idx     <= '0;
                        r_gap     <= '0;
                        r_gap_tbs <= !can_rdata[2];
                        r_state   <= can_rdata[2] ? LOAD : GAP;
                    end
                    LOAD: begin
                        can_cs    <= 1'b1;
                        can_we    <= 1'b1;
                        can_addr  <= 8'd16 + {4'd0, r_idx};
                        can_wdata <= r_mb[r_active][r_idx];
                        r_idx     <= r_idx + 4'd1;
                        r_state   <= r_idx == 4'd12 ? CMD : LOAD;
                    end
                    CMD, ABRT: begin
                        can_cs       <= 1'b1;
                        can_we       <= 1'b1;
                        can_addr     <= 8'd1;
                        can_wdata    <= r_state == CMD ? 8'h01 : 8'h02;
                        r_abort_sent <= r_abort_sent || r_state == ABRT;
                        r_gap_tbs    <= 1'b0;
                        r_gap        <= '0;
                        r_state      <= GAP;
                    end
                    GAP: begin
                        if (r_abort && !r_abort_sent && !r_gap_tbs) begin
                            r_state <= ABRT;
                        end else if (r_gap == GW'(POLL_GAP - 1)) begin
                            r_gap   <= '0;
                            r_state <= r_gap_tbs ? RD_TBS : RD_SR;
                        end else begin
                            r_gap <= r_gap + 1'b1;
                        end
                    end
                    CK_SR: begin
                        r_err   <= !can_rdata[3];
                        r_gap   <= '0;
                        r_state <= (can_rdata[3] || (r_abort_sent && can_rdata[2])) ? DONE : GAP;
                    end
                    DONE: begin
                        done_pulse          <= 1'b1;
                        done_slot           <= r_active;
                        done_err            <= r_err;
                        r_pending[r_active] <= 1'b0;
                        r_busy              <= 1'b0;
                        r_state             <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

endmodule
